// File: rtl/stack_up_arbiter.sv
// stack_up_arbiter: per-manager FIFOs merged onto one stack-up link, round-robin per packet; STACK_UP_ARBITER_TIMEOUT_EN adds a starvation timeout
module stack_up_arbiter #(
  parameter int NUM_MGR     = 4,
  parameter int MGR_ID_W    = 2,
  parameter int TYPE_W      = 2,
  parameter int DATA_W      = 64,
  parameter int OOB_W       = 32,
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                      clk,
  input  logic                      reset_poweron,
  input  logic [NUM_MGR-1:0]        mgr__sua__valid,
  input  logic [2*NUM_MGR-1:0]      mgr__sua__cntl,
  output logic [NUM_MGR-1:0]        sua__mgr__ready,
  input  logic [TYPE_W*NUM_MGR-1:0] mgr__sua__type,
  input  logic [DATA_W*NUM_MGR-1:0] mgr__sua__data,
  input  logic [OOB_W*NUM_MGR-1:0]  mgr__sua__oob_data,
  output logic                      sua__sys__valid,
  output logic [1:0]                sua__sys__cntl,
  input  logic                      sys__sua__ready,
  output logic [TYPE_W-1:0]         sua__sys__type,
  output logic [DATA_W-1:0]         sua__sys__data,
  output logic [OOB_W-1:0]          sua__sys__oob_data,
  output logic [MGR_ID_W-1:0]       sua__sys__mgrId,
  output logic                      sua__sys__err
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = 2 + TYPE_W + DATA_W + OOB_W;
  typedef enum logic {IDLE, XFER} state_t;
  state_t state, state_n;
  logic [MGR_ID_W-1:0] g, g_n, rr_ptr, rr_n, pick;
  logic found, can_load, pop, tmo;
  logic [NUM_MGR-1:0] empty;
  logic [EW-1:0] mem [NUM_MGR][FIFO_DEPTH];
  logic [AW-1:0] rd_ptr [NUM_MGR];
  logic [EW-1:0] head;
  assign head = mem[g][rd_ptr[g]];
  for (genvar i = 0; i < NUM_MGR; i++) begin : g_fifo
    logic push, pop_i, rdy;
    logic [AW-1:0] wr_ptr;
    logic [AW:0] cnt, cnt_n;
    assign push = mgr__sua__valid[i] && rdy;
    assign pop_i = pop && g == MGR_ID_W'(i);
    assign empty[i] = cnt == '0;
    assign cnt_n = cnt + (AW+1)'(push) - (AW+1)'(pop_i);
    assign sua__mgr__ready[i] = rdy;
    // store each accepted beat as {cntl, type, data, oob}
    always_ff @(posedge clk)
      if (push) mem[i][wr_ptr] <= {mgr__sua__cntl[2*i +: 2], mgr__sua__type[TYPE_W*i +: TYPE_W],
                                   mgr__sua__data[DATA_W*i +: DATA_W], mgr__sua__oob_data[OOB_W*i +: OOB_W]};
    // pointers, occupancy and registered not-full ready
    always_ff @(posedge clk or posedge reset_poweron)
      if (reset_poweron) begin
        rd_ptr[i] <= '0;
        wr_ptr <= '0;
        cnt <= '0;
        rdy <= 1'b1;
      end else begin
        rd_ptr[i] <= rd_ptr[i] + AW'(pop_i);
        wr_ptr <= wr_ptr + AW'(push);
        cnt <= cnt_n;
        rdy <= cnt_n < (AW+1)'(FIFO_DEPTH);
      end
  end
  // round-robin scan from the pointer, packet transfer and return to IDLE on end of packet
  always_comb begin
    found = 1'b0;
    pick = '0;
    for (int k = NUM_MGR - 1; k >= 0; k--)
      if (!empty[MGR_ID_W'((int'(rr_ptr) + k) % NUM_MGR)]) begin
        found = 1'b1;
        pick = MGR_ID_W'((int'(rr_ptr) + k) % NUM_MGR);
      end
    can_load = !sua__sys__valid || sys__sua__ready;
    pop = state == XFER && can_load && !empty[g];
    state_n = state;
    g_n = g;
    rr_n = rr_ptr;
    if (state == IDLE && found) begin
      state_n = XFER;
      g_n = pick;
    end
    if ((pop && head[EW-1]) || tmo) begin
      state_n = IDLE;
      rr_n = g == MGR_ID_W'(NUM_MGR - 1) ? '0 : g + 1'b1;
    end
  end
  // FSM state, current grant and round-robin pointer
  always_ff @(posedge clk or posedge reset_poweron)
    if (reset_poweron) begin
      state <= IDLE;
      g <= '0;
      rr_ptr <= '0;
    end else begin
      state <= state_n;
      g <= g_n;
      rr_ptr <= rr_n;
    end
  // single output stage: load on pop or synthetic EOM, drop valid once accepted
  always_ff @(posedge clk or posedge reset_poweron)
    if (reset_poweron) begin
      sua__sys__valid <= 1'b0;
      {sua__sys__cntl, sua__sys__type, sua__sys__data, sua__sys__oob_data} <= '0;
      sua__sys__mgrId <= '0;
    end else if (pop) begin
      sua__sys__valid <= 1'b1;
      {sua__sys__cntl, sua__sys__type, sua__sys__data, sua__sys__oob_data} <= head;
      sua__sys__mgrId <= g;
    end else if (tmo) begin
      sua__sys__valid <= 1'b1;
      {sua__sys__cntl, sua__sys__type, sua__sys__data, sua__sys__oob_data} <= {2'b10, {(EW-2){1'b0}}};
      sua__sys__mgrId <= g;
    end else if (sys__sua__ready)
      sua__sys__valid <= 1'b0;
`ifdef STACK_UP_ARBITER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tmo_cnt;
  assign tmo = state == XFER && empty[g] && !sua__sys__valid && tmo_cnt == TW'(TIMEOUT_CYC - 1);
  // starvation counter while the granted FIFO runs dry, and sticky error
  always_ff @(posedge clk or posedge reset_poweron)
    if (reset_poweron) begin
      tmo_cnt <= '0;
      sua__sys__err <= 1'b0;
    end else begin
      tmo_cnt <= (state != XFER || pop || tmo) ? '0 : (empty[g] && !sua__sys__valid) ? tmo_cnt + 1'b1 : tmo_cnt;
      sua__sys__err <= sua__sys__err || tmo;
    end
`else
  assign tmo = TIMEOUT_CYC < 0;
  assign sua__sys__err = 1'b0;
`endif
endmodule
